// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//   Bit-serial to word-parallel converter. One data bit is shifted in per
//   enabled clock, LSB first. When the sender flags the last (MSB) bit, the
//   assembled LENGTH-bit word is registered onto o_dout. A frame that ends
//   with fewer than LENGTH bits raises o_frame_err instead.
//
//   Optional feature macro: SERIAL_WORD_DESERIALIZER_PARITY_EN
//     When defined, the enabled edge after a good frame is a parity slot.
//     i_par_bit is sampled there and checked for even parity against o_dout.
//     o_par_err pulses on a mismatch. The parity slot does not shift data
//     and is not counted into the next frame.
//
//   Ports
//     i_clk        : clock, rising edge active
//     i_rst        : asynchronous active-low reset
//     i_en         : clock enable
//     i_din        : serial data bit, LSB first
//     i_din_valid  : high with the last (MSB) bit of a frame
//     i_par_bit    : even parity bit (parity build only)
//     o_dout       : last good word, held until the next good frame
//     o_dout_valid : one-cycle pulse when o_dout updates
//     o_frame_err  : one-cycle pulse when a frame ends short
//     o_par_err    : one-cycle pulse on a parity mismatch (parity build only)
module serial_word_deserializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  input  logic              i_par_bit,
  output logic              o_par_err,
`endif
  output logic [LENGTH-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_frame_err
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LENGTH);
  localparam logic [CW-1:0] CNT_GOOD = CW'(LENGTH - 1);

  logic [LENGTH-1:0] sr_r;
  logic [CW-1:0]     cnt_r;
  logic [LENGTH-1:0] shifted_s;
  logic              good_s;

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  logic              par_pending_r;

  // Even parity over a stored word: the expected parity bit is the XOR of all bits.
  function automatic logic even_parity(input logic [LENGTH-1:0] word);
    even_parity = ^word;
  endfunction
`endif

  // Next shift-register image (current bit enters at the MSB) and good-frame test.
  always_comb begin
    shifted_s = {i_din, sr_r[LENGTH-1:1]};
    good_s    = (cnt_r >= CNT_GOOD);
  end

  // Datapath, bit counter and registered output pulses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sr_r         <= '0;
      cnt_r        <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      par_pending_r <= 1'b0;
      o_par_err     <= 1'b0;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      o_dout_valid <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      o_par_err    <= 1'b0;
`endif
      if (i_en) begin
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
        if (par_pending_r) begin
          // Parity slot: data inputs are ignored, shift state is held.
          par_pending_r <= 1'b0;
          o_par_err     <= (even_parity(o_dout) != i_par_bit);
        end else begin
`endif
          sr_r <= shifted_s;
          if (i_din_valid) begin
            cnt_r <= '0;
            if (good_s) begin
              o_dout       <= shifted_s;
              o_dout_valid <= 1'b1;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
              par_pending_r <= 1'b1;
`endif
            end else begin
              o_frame_err <= 1'b1;
            end
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            // Saturated: an overlong frame keeps a sliding window of bits.
            cnt_r <= cnt_r;
          end
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
        end
`endif
      end else begin
        sr_r  <= sr_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer
//   Directed and randomized stimulus for serial_word_deserializer. A
//   behavioural model holds the bits of the current frame in a queue and
//   derives the expected word, pulses and parity result from them; outputs
//   are compared one time unit after every rising edge.
module tb_serial_word_deserializer;

  localparam int LENGTH = 24;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              tb_clk = 1'b0;
  logic              tb_rst = 1'b0;
  logic              tb_en = 1'b0;
  logic              tb_din = 1'b0;
  logic              tb_last = 1'b0;
  logic              tb_par = 1'b0;
  logic [LENGTH-1:0] o_dout;
  logic              o_dout_valid;
  logic              o_frame_err;
  logic              o_par_err_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_count = 0;
  int pulse_cyc[$];

  // model state
  bit                q[$];
  logic [LENGTH-1:0] exp_dout = '0;
  logic              exp_valid = 1'b0;
  logic              exp_err = 1'b0;
  logic              exp_perr = 1'b0;
  bit                par_pending = 1'b0;

  serial_word_deserializer #(.LENGTH(LENGTH)) dut (
    .i_clk        (tb_clk),
    .i_rst        (tb_rst),
    .i_en         (tb_en),
    .i_din        (tb_din),
    .i_din_valid  (tb_last),
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    .i_par_bit    (tb_par),
    .o_par_err    (o_par_err_s),
`endif
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .o_frame_err  (o_frame_err)
  );

`ifndef SERIAL_WORD_DESERIALIZER_PARITY_EN
  assign o_par_err_s = 1'b0;
`endif

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout    = '0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    exp_perr    = 1'b0;
    par_pending = 1'b0;
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, compare 1 later.
  task automatic step(input logic en, input logic din, input logic last, input logic par);
    @(negedge tb_clk);
    tb_en = en; tb_din = din; tb_last = last; tb_par = par;
    @(posedge tb_clk);
    exp_valid = 1'b0; exp_err = 1'b0; exp_perr = 1'b0;
    if (en) begin
      if (par_pending) begin
        exp_perr    = ((^exp_dout) != par);
        par_pending = 1'b0;
      end else begin
        q.push_back(din);
        if (q.size() > LENGTH) void'(q.pop_front());
        if (last) begin
          if (q.size() == LENGTH) begin
            for (int i = 0; i < LENGTH; i++) exp_dout[i] = q[i];
            exp_valid   = 1'b1;
            par_pending = PAR_EN;
          end else begin
            exp_err = 1'b1;
          end
          q.delete();
        end
      end
    end
    #1;
    if (o_dout_valid === 1'b1) begin
      valid_count++;
      pulse_cyc.push_back(cyc);
    end
    chk("dout", 64'(o_dout), 64'(exp_dout));
    chk("dout_valid", 64'(o_dout_valid), 64'(exp_valid));
    chk("frame_err", 64'(o_frame_err), 64'(exp_err));
    if (PAR_EN) chk("par_err", 64'(o_par_err_s), 64'(exp_perr));
  endtask

  // Parity slot after a good frame (parity build only).
  task automatic par_slot();
    if (PAR_EN && par_pending) step(1'b1, 1'($urandom_range(1, 0)), 1'b0, ^exp_dout);
  endtask

  // Send nbits of w LSB-first with the frame marker on the final bit.
  task automatic send_word(input logic [63:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) step(1'b1, w[i], (i == nbits - 1), 1'b0);
    par_slot();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_pulse();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    tb_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", 64'(o_dout), 64'd0);
    chk("rst_valid", 64'(o_dout_valid), 64'd0);
    chk("rst_err", 64'(o_frame_err), 64'd0);
    @(negedge tb_clk);
    tb_rst = 1'b1;
  endtask

  initial begin
    logic [23:0] w;
    logic [63:0] lw;
    int          vc0;

    // reset state
    repeat (3) @(posedge tb_clk);
    #1;
    chk("reset_dout", 64'(o_dout), 64'd0);
    chk("reset_valid", 64'(o_dout_valid), 64'd0);
    chk("reset_err", 64'(o_frame_err), 64'd0);
    @(negedge tb_clk);
    tb_rst = 1'b1;

    // single word
    send_word(64'hA5C3F0, 24);
    chk("single_dout", 64'(o_dout), 64'hA5C3F0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_pulse_count", 64'(valid_count), 64'd1);

    // random words, each followed by a reset pulse
    for (int n = 0; n < 100; n++) begin
      w = 24'($urandom);
      send_word(64'(w), 24);
      chk("random_dout", 64'(o_dout), 64'(w));
      reset_pulse();
    end

    // short frame keeps the previous word
    send_word(64'h5A5A5A, 24);
    send_word(64'h3FF, 10);
    chk("short_err", 64'(o_frame_err), 64'd1);
    chk("short_dout_held", 64'(o_dout), 64'h5A5A5A);
    send_word(64'h123456, 24);
    chk("after_short_dout", 64'(o_dout), 64'h123456);

    // enable gap with toggling inputs
    vc0 = valid_count;
    lw = 64'hFEDCBA;
    for (int i = 0; i < 12; i++) step(1'b1, lw[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
    for (int i = 12; i < 24; i++) step(1'b1, lw[i], (i == 23), 1'b0);
    par_slot();
    chk("gap_dout", 64'(o_dout), 64'hFEDCBA);
    chk("gap_pulses", 64'(valid_count - vc0), 64'd1);

    // asynchronous reset mid-frame
    vc0 = valid_count;
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    reset_pulse();
    chk("midrst_no_pulse", 64'(valid_count - vc0), 64'd0);
    send_word(64'h000001, 24);
    chk("midrst_next_dout", 64'(o_dout), 64'h000001);

    // back-to-back frames
    pulse_cyc.delete();
    send_word(64'h111111, 24);
    chk("b2b_first", 64'(o_dout), 64'h111111);
    send_word(64'h222222, 24);
    chk("b2b_second", 64'(o_dout), 64'h222222);
    chk("b2b_pulses", 64'(pulse_cyc.size()), 64'd2);
    if (pulse_cyc.size() == 2)
      chk("b2b_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), PAR_EN ? 64'd25 : 64'd24);

    // overlong frame: last 24 of 30 bits form the word
    lw = (64'hABCDEF << 6) | 64'($urandom_range(63, 0));
    send_word(lw, 30);
    chk("overlong_dout", 64'(o_dout), 64'hABCDEF);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
